mem_port_arbiter: RTL and testbench

Shares the single-port data/instruction memory between the pipeline's instruction fetch (IF) requester and the MEM-stage data (DM) requester. It grants one requester at a time and drives the memory port for a fixed access latency. It returns read data and a one-cycle valid pulse, and produces per-requester stall signals the pipeline uses to freeze its stage registers. Data accesses have priority; a starvation counter guarantees forward progress for fetch.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_starve_cnt.sv | 39 +++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and default sizes for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_IF = 2'd1,
        ACC_DM = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_t;

    localparam int c_def_addr_w      = 32;
    localparam int c_def_data_w      = 32;
    localparam int c_def_mem_latency = 1;
    localparam int c_def_starve_max  = 4;

endpackage

`default_nettype wire

// File: rtl/mem_arb_starve_cnt.sv
// ============================================================================
// Module      : mem_arb_starve_cnt
// Description : Saturating count of data grants that bypassed a pending fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int MAX = c_def_starve_max
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    // One spare code keeps the width non-zero even when MAX is 0.
    localparam int c_cnt_w = $clog2(MAX + 2);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != c_cnt_w'(MAX))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign at_max = (r_cnt == c_cnt_w'(MAX));

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between fetch and data requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = c_def_addr_w,
    parameter int DATA_W      = c_def_data_w,
    parameter int MEM_LATENCY = c_def_mem_latency,
    parameter int STARVE_MAX  = c_def_starve_max
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_stall,
    output logic              dm_stall,
    output logic              busy
);

    generate
        if (MEM_LATENCY < 1) begin : g_bad_latency
            $error("mem_port_arbiter: MEM_LATENCY must be >= 1");
        end
    endgenerate

    localparam int c_lat_w = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);

    arb_state_t         r_state;
    logic [c_lat_w-1:0] r_lat_cnt;

    logic    w_if_eff;
    logic    w_dm_eff;
    logic    w_any;
    logic    w_at_max;
    logic    w_arb;
    req_id_t w_winner;

    // A requester still holding its level during its valid cycle is not a new request.
    assign w_if_eff = if_req & ~if_valid;
    assign w_dm_eff = dm_req & ~dm_valid;
    assign w_any    = w_if_eff | w_dm_eff;
    assign w_arb    = (r_state == IDLE) & w_any;
    assign w_winner = (w_if_eff && (!w_dm_eff || w_at_max)) ? REQ_IF : REQ_DM;

    mem_arb_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (w_arb & (w_winner == REQ_DM) & w_if_eff),
        .clr    (w_arb & (w_winner == REQ_IF)),
        .at_max (w_at_max)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_lat_cnt <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_arb) begin
                        r_lat_cnt <= c_lat_w'(MEM_LATENCY);
                        if (w_winner == REQ_IF) begin
                            mem_addr <= if_addr;
                            mem_we   <= 1'b0;
                            r_state  <= ACC_IF;
                        end else begin
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            mem_we    <= dm_we;
                            r_state   <= ACC_DM;
                        end
                    end
                end
                ACC_IF, ACC_DM: begin
                    r_lat_cnt <= r_lat_cnt - 1'b1;
                    if (r_lat_cnt == c_lat_w'(1)) begin
                        if (r_state == ACC_IF) begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end else begin
                            // Latched mem_we distinguishes stores even if dm_we moved mid-access.
                            if (!mem_we) begin
                                dm_rdata <= mem_rdata;
                            end
                            dm_valid <= 1'b1;
                        end
                        mem_we  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    mem_we  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_valid;
    assign busy     = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed bench for mem_port_arbiter at latencies 1, 3 and 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset    [3];
    logic        if_req   [3];
    logic [31:0] if_addr  [3];
    logic [31:0] if_rdata [3];
    logic        if_valid [3];
    logic        dm_req   [3];
    logic        dm_we    [3];
    logic [31:0] dm_addr  [3];
    logic [31:0] dm_wdata [3];
    logic [31:0] dm_rdata [3];
    logic        dm_valid [3];
    logic [31:0] mem_addr [3];
    logic [31:0] mem_wdata[3];
    logic        mem_we   [3];
    logic [31:0] mem_rdata[3];
    logic        if_stall [3];
    logic        dm_stall [3];
    logic        busy     [3];

    int n_chk  = 0;
    int n_fail = 0;

    // Instance 0: latency 1, instance 1: latency 3, instance 2: latency 4.
    generate
        for (genvar k = 0; k < 3; k++) begin : g_dut
            localparam int LAT = (k == 0) ? 1 : ((k == 1) ? 3 : 4);
            logic [31:0] mem [16];

            mem_port_arbiter #(
                .ADDR_W      (32),
                .DATA_W      (32),
                .MEM_LATENCY (LAT),
                .STARVE_MAX  (4)
            ) u_dut (
                .clk       (clk),
                .reset     (reset[k]),
                .if_req    (if_req[k]),
                .if_addr   (if_addr[k]),
                .if_rdata  (if_rdata[k]),
                .if_valid  (if_valid[k]),
                .dm_req    (dm_req[k]),
                .dm_we     (dm_we[k]),
                .dm_addr   (dm_addr[k]),
                .dm_wdata  (dm_wdata[k]),
                .dm_rdata  (dm_rdata[k]),
                .dm_valid  (dm_valid[k]),
                .mem_addr  (mem_addr[k]),
                .mem_wdata (mem_wdata[k]),
                .mem_we    (mem_we[k]),
                .mem_rdata (mem_rdata[k]),
                .if_stall  (if_stall[k]),
                .dm_stall  (dm_stall[k]),
                .busy      (busy[k])
            );

            // Word i preloads to 19*i while reset is held low.
            always @(posedge clk) begin
                if (!reset[k]) begin
                    for (int i = 0; i < 16; i++) mem[i] <= 32'(i * 19);
                end else if (mem_we[k]) begin
                    mem[mem_addr[k][5:2]] <= mem_wdata[k];
                end
            end
            assign mem_rdata[k] = mem[mem_addr[k][5:2]];
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Fetch held pending while data keeps re-requesting; fetch drops only in
    // the data-valid cycle so every data grant sees a pending fetch.
    task automatic starve_run(output int ndm, output logic got);
        ndm = 0;
        got = 1'b0;
        if_req[0] = 1'b1; if_addr[0] = 32'h4;
        dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h8;
        for (int c = 0; c < 40 && !got; c++) begin
            tick();
            if (if_valid[0]) begin
                got = 1'b1;
                chk("starve_if_rdata", if_rdata[0], 32'd19);
            end else if (dm_valid[0]) begin
                ndm++;
                if_req[0] = 1'b0;
            end else begin
                if_req[0] = 1'b1;
            end
        end
        if_req[0] = 1'b0;
        dm_req[0] = 1'b0;
    endtask

    initial begin
        int   ndm;
        logic got;
        for (int k = 0; k < 3; k++) begin
            reset[k] = 1'b0; if_req[k] = 1'b0; if_addr[k] = '0;
            dm_req[k] = 1'b0; dm_we[k] = 1'b0; dm_addr[k] = '0; dm_wdata[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_valid", if_valid[0], 1'b0);
        chk("rst_dm_valid", dm_valid[0], 1'b0);
        chk("rst_mem_we", mem_we[0], 1'b0);
        chk("rst_mem_addr", mem_addr[0], 32'h0);
        chk("rst_mem_wdata", mem_wdata[0], 32'h0);
        chk("rst_if_rdata", if_rdata[0], 32'h0);
        chk("rst_dm_rdata", dm_rdata[0], 32'h0);
        chk("rst_busy", busy[0], 1'b0);
        for (int k = 0; k < 3; k++) reset[k] = 1'b1;
        tick();

        // Single fetch at latency 1
        if_req[0] = 1'b1; if_addr[0] = 32'h4;
        #1;
        chk("if_stall_pre", if_stall[0], 1'b1);
        tick();
        chk("if_busy", busy[0], 1'b1);
        chk("if_mem_addr", mem_addr[0], 32'h4);
        chk("if_valid_early", if_valid[0], 1'b0);
        chk("if_stall_wait", if_stall[0], 1'b1);
        tick();
        chk("if_valid", if_valid[0], 1'b1);
        chk("if_rdata", if_rdata[0], 32'd19);
        chk("if_stall_done", if_stall[0], 1'b0);
        chk("if_busy_done", busy[0], 1'b0);
        if_req[0] = 1'b0;
        tick();
        chk("if_valid_pulse", if_valid[0], 1'b0);

        // Store then load
        dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 32'h8; dm_wdata[0] = 32'hAB;
        tick();
        chk("st_mem_we", mem_we[0], 1'b1);
        chk("st_mem_addr", mem_addr[0], 32'h8);
        chk("st_mem_wdata", mem_wdata[0], 32'hAB);
        chk("st_dm_stall", dm_stall[0], 1'b1);
        tick();
        chk("st_dm_valid", dm_valid[0], 1'b1);
        chk("st_mem_we_off", mem_we[0], 1'b0);
        chk("st_dm_rdata", dm_rdata[0], 32'h0);
        dm_req[0] = 1'b0;
        tick();
        dm_req[0] = 1'b1; dm_we[0] = 1'b0;
        tick();
        chk("ld_mem_we", mem_we[0], 1'b0);
        chk("ld_mem_addr", mem_addr[0], 32'h8);
        tick();
        chk("ld_dm_valid", dm_valid[0], 1'b1);
        chk("ld_dm_rdata", dm_rdata[0], 32'hAB);
        dm_req[0] = 1'b0;
        tick();
        dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 32'hC; dm_wdata[0] = 32'hCD;
        tick();
        tick();
        chk("st2_dm_valid", dm_valid[0], 1'b1);
        chk("st2_dm_rdata_hold", dm_rdata[0], 32'hAB);
        dm_req[0] = 1'b0; dm_we[0] = 1'b0;
        tick();

        // Simultaneous requests: data first, fetch two cycles later
        if_req[0] = 1'b1; if_addr[0] = 32'h4;
        dm_req[0] = 1'b1; dm_addr[0] = 32'h8;
        tick();
        chk("sim_first_addr", mem_addr[0], 32'h8);
        tick();
        chk("sim_dm_valid", dm_valid[0], 1'b1);
        chk("sim_if_not_yet", if_valid[0], 1'b0);
        dm_req[0] = 1'b0;
        tick();
        chk("sim_second_addr", mem_addr[0], 32'h4);
        chk("sim_dm_pulse", dm_valid[0], 1'b0);
        tick();
        chk("sim_if_valid", if_valid[0], 1'b1);
        chk("sim_if_rdata", if_rdata[0], 32'd19);
        if_req[0] = 1'b0;
        tick();

        // Starvation: four data grants then fetch, twice (counter must clear)
        starve_run(ndm, got);
        chk("starve1_got_if", got, 1'b1);
        chk("starve1_dm_grants", ndm, 32'd4);
        tick();
        tick();
        starve_run(ndm, got);
        chk("starve2_got_if", got, 1'b1);
        chk("starve2_dm_grants", ndm, 32'd4);
        tick();

        // Latency 4 fetch
        if_req[2] = 1'b1; if_addr[2] = 32'h4;
        tick();
        chk("lat4_busy0", busy[2], 1'b1);
        chk("lat4_addr0", mem_addr[2], 32'h4);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("lat4_busy", busy[2], 1'b1);
            chk("lat4_addr", mem_addr[2], 32'h4);
            chk("lat4_no_valid", if_valid[2], 1'b0);
        end
        tick();
        chk("lat4_valid", if_valid[2], 1'b1);
        chk("lat4_rdata", if_rdata[2], 32'd19);
        chk("lat4_idle", busy[2], 1'b0);
        if_req[2] = 1'b0;
        tick();
        chk("lat4_pulse", if_valid[2], 1'b0);

        // Reset in the middle of a latency-3 store
        dm_req[1] = 1'b1; dm_we[1] = 1'b1; dm_addr[1] = 32'h10; dm_wdata[1] = 32'h55;
        tick();
        chk("rma_mem_we", mem_we[1], 1'b1);
        chk("rma_busy", busy[1], 1'b1);
        tick();
        chk("rma_mem_we_held", mem_we[1], 1'b1);
        reset[1] = 1'b0;
        #1;
        chk("rma_mem_we_drop", mem_we[1], 1'b0);
        chk("rma_busy_drop", busy[1], 1'b0);
        chk("rma_no_valid", dm_valid[1], 1'b0);
        dm_req[1] = 1'b0; dm_we[1] = 1'b0;
        tick();
        tick();
        reset[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rma_idle_after", busy[1], 1'b0);
            chk("rma_no_valid_after", dm_valid[1], 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
